// File: rtl/eth_frame_writer_pkg.sv
// rtl/eth_frame_writer_pkg.sv - shared types and widths for the ethernet frame writer
package eth_frame_writer_pkg;

  localparam int ETH_MAC_W  = 48;
  localparam int ETH_TYPE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TX,
    HDR,
    PAYLOAD,
    DONE
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count, pointers wrap at DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop frees a slot the same cycle
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  // Storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth makes pointer wrap free
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/eth_frame_writer.sv
// rtl/eth_frame_writer.sv - buffers payload beats and emits header plus payload stream per frame
module eth_frame_writer
  import eth_frame_writer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [ETH_MAC_W-1:0]  dest_mac,
  input  logic [ETH_MAC_W-1:0]  src_mac,
  input  logic [ETH_TYPE_W-1:0] eth_type,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  tx_busy,
  input  logic                  s_eth_hdr_ready,
  input  logic                  s_eth_payload_axis_tready,
  output logic                  s_eth_hdr_valid,
  output logic [ETH_MAC_W-1:0]  s_eth_dest_mac,
  output logic [ETH_MAC_W-1:0]  s_eth_src_mac,
  output logic [ETH_TYPE_W-1:0] s_eth_type,
  output logic [DATA_W-1:0]     s_eth_payload_axis_tdata,
  output logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tlast,
  output logic                  s_eth_payload_axis_tuser,
  output logic                  busy,
  output logic                  valid,
  output logic                  err
);

  state_t                            state_q;
  state_t                            state_d;
  logic [LEN_W-1:0]                  len_q;
  logic [ETH_MAC_W-1:0]              dest_q;
  logic [ETH_MAC_W-1:0]              src_q;
  logic [ETH_TYPE_W-1:0]             type_q;
  logic [LEN_W-1:0]                  beat_cnt;
  logic                              err_q;
  logic [DATA_W-1:0]                 fifo_head;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   unused_fifo_count;
  logic                              fifo_pop;
  logic                              is_last;
  logic                              frame_req;

  // in_ready comes only from the registered occupancy, never from tready
  assign in_ready  = !fifo_full;
  assign frame_req = (state_q == IDLE) && start;
  assign is_last   = (beat_cnt == len_q - LEN_W'(1));
  assign fifo_pop  = (state_q == PAYLOAD) && !fifo_empty && s_eth_payload_axis_tready;
  assign err       = err_q;
  assign s_eth_payload_axis_tuser = 1'b0;

  sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid && in_ready),
    .push_data(in_data),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (unused_fifo_count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; outputs are zero outside their owning state
  always_comb begin
    state_d                   = state_q;
    busy                      = (state_q != IDLE);
    valid                     = 1'b0;
    s_eth_hdr_valid           = 1'b0;
    s_eth_dest_mac            = '0;
    s_eth_src_mac             = '0;
    s_eth_type                = '0;
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tdata  = '0;
    s_eth_payload_axis_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && len != '0) begin
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (!tx_busy) begin
          state_d = HDR;
        end
      end
      HDR: begin
        s_eth_hdr_valid = 1'b1;
        s_eth_dest_mac  = dest_q;
        s_eth_src_mac   = src_q;
        s_eth_type      = type_q;
        if (s_eth_hdr_ready) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!fifo_empty) begin
          s_eth_payload_axis_tvalid = 1'b1;
          s_eth_payload_axis_tdata  = fifo_head;
          s_eth_payload_axis_tlast  = is_last;
        end
        if (fifo_pop && is_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame parameters, beat counter and the zero-length reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      type_q   <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= frame_req && (len == '0);
      if (frame_req && len != '0) begin
        len_q  <= len;
        dest_q <= dest_mac;
        src_q  <= src_mac;
        type_q <= eth_type;
      end
      if (state_q == WAIT_TX) begin
        beat_cnt <= '0;
      end else if (fifo_pop) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_writer.sv
// tb/tb_eth_frame_writer.sv - directed self-checking bench for eth_frame_writer
module tb_eth_frame_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx_busy;
  logic        hdr_ready;
  logic        tready;
  logic        hdr_valid;
  logic [47:0] o_dest;
  logic [47:0] o_src;
  logic [15:0] o_type;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic        busy;
  logic        valid;
  logic        err;

  int errors = 0;
  int checks = 0;
  int pushed;
  int rcv;
  logic seen;

  localparam logic [47:0] DMAC = 48'h0102_0304_0506;
  localparam logic [47:0] SMAC = 48'h0A0B_0C0D_0E0F;
  localparam logic [15:0] ETYP = 16'h0800;

  eth_frame_writer #(.DATA_W(8), .FIFO_DEPTH(16), .LEN_W(16)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .len                      (len),
    .dest_mac                 (dest_mac),
    .src_mac                  (src_mac),
    .eth_type                 (eth_type),
    .in_data                  (in_data),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .tx_busy                  (tx_busy),
    .s_eth_hdr_ready          (hdr_ready),
    .s_eth_payload_axis_tready(tready),
    .s_eth_hdr_valid          (hdr_valid),
    .s_eth_dest_mac           (o_dest),
    .s_eth_src_mac            (o_src),
    .s_eth_type               (o_type),
    .s_eth_payload_axis_tdata (tdata),
    .s_eth_payload_axis_tvalid(tvalid),
    .s_eth_payload_axis_tlast (tlast),
    .s_eth_payload_axis_tuser (tuser),
    .busy                     (busy),
    .valid                    (valid),
    .err                      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0;
    dest_mac = DMAC; src_mac = SMAC; eth_type = ETYP;
    in_data = '0; in_valid = 1'b0;
    tx_busy = 1'b0; hdr_ready = 1'b1; tready = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_hdr_valid", hdr_valid, 0);
    check_eq("rst_tvalid", tvalid, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // basic frame of 4 beats, a fifth beat left over for the next frame
    push_beats(5, 8'h11);
    start_frame(16'd4);
    check_eq("f1_busy_wait", busy, 1);
    check_eq("f1_hdr_wait", hdr_valid, 0);
    tick();
    check_eq("f1_hdr_valid", hdr_valid, 1);
    check_eq("f1_dest", o_dest, DMAC);
    check_eq("f1_src", o_src, SMAC);
    check_eq("f1_type", o_type, ETYP);
    check_eq("f1_tvalid_in_hdr", tvalid, 0);
    tick();
    check_eq("f1_hdr_drop", hdr_valid, 0);
    check_eq("f1_dest_zero", o_dest, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("f1_tvalid", tvalid, 1);
      check_eq("f1_tdata", tdata, 8'h11 + 8'(i));
      check_eq("f1_tlast", tlast, (i == 3) ? 1 : 0);
      check_eq("f1_tuser", tuser, 0);
      tick();
    end
    check_eq("f1_valid", valid, 1);
    check_eq("f1_tvalid_done", tvalid, 0);
    tick();
    check_eq("f1_valid_pulse", valid, 0);
    check_eq("f1_idle", busy, 0);

    // zero-length request is rejected
    start_frame(16'd0);
    check_eq("z_err", err, 1);
    check_eq("z_busy", busy, 0);
    check_eq("z_hdr", hdr_valid, 0);
    tick();
    check_eq("z_err_pulse", err, 0);
    check_eq("z_busy2", busy, 0);

    // downstream busy holds off the header; header stable while hdr_ready low
    tx_busy = 1'b1;
    start_frame(16'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("tb_hdr_held", hdr_valid, 0);
      tick();
    end
    check_eq("tb_still_busy", busy, 1);
    tx_busy   = 1'b0;
    hdr_ready = 1'b0;
    tick();
    check_eq("tb_hdr_valid", hdr_valid, 1);
    tick();
    check_eq("tb_hdr_stable", hdr_valid, 1);
    check_eq("tb_src_stable", o_src, SMAC);
    hdr_ready = 1'b1;
    tick();
    check_eq("lo_tvalid", tvalid, 1);
    check_eq("lo_tdata", tdata, 8'h15);
    check_eq("lo_tlast", tlast, 1);
    tick();
    check_eq("lo_valid", valid, 1);
    tick();

    // fill to 16 entries, then stream 20 beats with tready toggling
    pushed = 0;
    for (int c = 0; c < 40 && in_ready; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(pushed + 1);
      #1;
      pushed++;
      tick();
    end
    in_valid = 1'b0;
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_count", pushed, 16);
    rcv   = 0;
    seen  = 1'b0;
    start = 1'b1;
    len   = 16'd20;
    for (int c = 0; c < 200; c++) begin
      if (valid) begin
        seen = 1'b1;
        break;
      end
      tready   = (c % 2 == 0);
      in_valid = (pushed < 20);
      in_data  = 8'(pushed + 1);
      #1;
      if (in_valid && in_ready) pushed++;
      if (tvalid && tready) begin
        check_eq("long_tdata", tdata, 8'(rcv + 1));
        check_eq("long_tlast", tlast, (rcv == 19) ? 1 : 0);
        rcv++;
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    tready   = 1'b1;
    check_eq("long_done", seen, 1);
    check_eq("long_beats", rcv, 20);
    check_eq("long_pushed", pushed, 20);
    tick();
    check_eq("long_in_ready", in_ready, 1);

    // underrun stall: only 2 of 3 beats available
    push_beats(2, 8'h31);
    start_frame(16'd3);
    tick();
    tick();
    check_eq("ur_b0", tdata, 8'h31);
    check_eq("ur_b0_last", tlast, 0);
    tick();
    check_eq("ur_b1", tdata, 8'h32);
    tick();
    check_eq("ur_stall_tvalid", tvalid, 0);
    check_eq("ur_stall_tlast", tlast, 0);
    tick();
    check_eq("ur_stall2_tvalid", tvalid, 0);
    check_eq("ur_stall_busy", busy, 1);
    in_valid = 1'b1;
    in_data  = 8'h33;
    tick();
    in_valid = 1'b0;
    check_eq("ur_b2_tvalid", tvalid, 1);
    check_eq("ur_b2", tdata, 8'h33);
    check_eq("ur_b2_last", tlast, 1);
    tick();
    check_eq("ur_valid", valid, 1);
    tick();

    // reset in the middle of a 6-beat frame
    push_beats(6, 8'h61);
    start_frame(16'd6);
    tick();
    tick();
    check_eq("mr_b0", tdata, 8'h61);
    tick();
    check_eq("mr_b1", tdata, 8'h62);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mr_busy", busy, 0);
    check_eq("mr_tvalid", tvalid, 0);
    check_eq("mr_tlast", tlast, 0);
    check_eq("mr_in_ready", in_ready, 1);
    check_eq("mr_valid", valid, 0);
    tick();
    check_eq("mr_valid2", valid, 0);
    check_eq("mr_tvalid2", tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_frame_writer.md
ETH_FRAME_WRITER -- requirements
Module: eth_frame_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload beat width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, payload buffer entries (power of two, >=2).
REQ-003 SHALL have parameter LEN_W, default 16, frame length field width in beats.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: start  in  1  frame request; len  in  LEN_W  payload beats; dest_mac/src_mac  in  48  header MACs; eth_type  in  16  ethertype.
REQ-006 SHALL have ports: in_data  in  DATA_W  payload beat; in_valid  in  1; in_ready  out  1  buffer has space.
REQ-007 SHALL have ports: tx_busy  in  1  downstream busy; s_eth_hdr_ready  in  1; s_eth_payload_axis_tready  in  1.
REQ-008 SHALL have ports: s_eth_hdr_valid  out  1; s_eth_dest_mac/s_eth_src_mac  out  48; s_eth_type  out  16.
REQ-009 SHALL have ports: s_eth_payload_axis_tdata  out  DATA_W; _tvalid/_tlast/_tuser  out  1 each.
REQ-010 SHALL have ports: busy  out  1  frame in progress; valid  out  1  one-cycle done pulse; err  out  1  one-cycle reject pulse.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_TX, HDR, PAYLOAD, DONE.
REQ-012 IDLE: start with len!=0 SHALL latch len and header fields and go to WAIT_TX next cycle; start with len==0 SHALL pulse err for one cycle and stay IDLE.
REQ-013 start SHALL be ignored in every state other than IDLE; busy SHALL be 1 in all states except IDLE.
REQ-014 WAIT_TX: SHALL go to HDR on the first cycle tx_busy==0.
REQ-015 HDR: s_eth_hdr_valid SHALL be 1 with latched header fields stable until the cycle s_eth_hdr_ready==1, then go to PAYLOAD.
REQ-016 PAYLOAD: tvalid SHALL equal buffer-not-empty; tdata SHALL be the buffer head; a beat transfers when tvalid&&tready.
REQ-017 tlast SHALL be 1 exactly on the beat whose index equals latched len-1; beat counter is LEN_W bits, zeroed on entry to HDR.
REQ-018 After the tlast transfer SHALL go to DONE; DONE SHALL assert valid for exactly one cycle and return to IDLE.
REQ-019 tuser SHALL be constant 0; outside HDR hdr_valid and header outputs SHALL be 0; outside PAYLOAD tvalid, tlast, tdata SHALL be 0.
REQ-020 Buffer SHALL accept a beat when in_valid&&in_ready in any state; in_ready SHALL be !full, registered (no combinational path from tready).
REQ-021 Full buffer with simultaneous pop SHALL not accept the push that cycle; simultaneous push and pop when not full/empty SHALL keep occupancy unchanged.
REQ-022 Empty buffer in PAYLOAD SHALL hold tvalid 0 with no beat counted (stall, no underrun).
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL range 0..FIFO_DEPTH exactly.
REQ-024 Beats beyond len left in buffer SHALL remain for the next frame.

Reset
REQ-025 rst SHALL force IDLE, empty buffer, counter 0, all outputs 0 except in_ready=1, on the next clk edge.
REQ-026 rst mid-frame SHALL abandon the frame without valid pulse and without tlast.

Structure
REQ-027 Shared package SHALL hold the FSM state enum, ETH_MAC_W=48, ETH_TYPE_W=16.
REQ-028 Buffer SHALL be one sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-029 len=4, bytes 0x11..0x14 preloaded, tready=1, hdr_ready=1 -> hdr 1 cycle, 4 beats, tlast on 0x14, valid pulse next cycle.
REQ-030 len=0 start -> err pulse 1 cycle, busy stays 0, no hdr_valid.
REQ-031 tx_busy=1 for 5 cycles after start -> hdr_valid stays 0 until tx_busy falls, then asserts next cycle.
REQ-032 len=20, FIFO_DEPTH=16, in_valid=1 continuously, tready toggling 1/0 -> in_ready drops at 16 entries, all 20 beats in order, no loss/duplicate.
REQ-033 Buffer empties after 2 of len=3 beats -> tvalid 0 until third push, third beat carries tlast.
REQ-034 rst asserted during PAYLOAD after beat 2 of 6 -> next cycle busy=0, tvalid=0, in_ready=1, no valid pulse.
